// File: rtl/jk_count_ctrl.sv
// Sequences LOAD/UP/DOWN/CLEAR into a JK flip-flop bank; N-step command takes N+1 cycles to done, cmd_len=0 takes 1.
// Single-command valid/ready: cmd_ready only in IDLE, a held request waits until the controller returns there.
module jk_count_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] start_rem;
  logic [WIDTH-1:0] tgt;
  logic             accept;
  logic             step_en;
  logic             wrap_hit;

  // LOAD and CLEAR are single-step commands; only UP/DOWN honour cmd_len.
  assign start_rem = (cmd_op == OP_UP || cmd_op == OP_DOWN) ? cmd_len : CNT_W'(1);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    step_en   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = (start_rem == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        step_en = 1'b1;
        if (rem == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tgt = q_fb;
    case (op_q)
      OP_LOAD:  tgt = data_q;
      OP_UP:    tgt = q_fb + WIDTH'(1);
      OP_DOWN:  tgt = q_fb - WIDTH'(1);
      OP_CLEAR: tgt = '0;
      default:  tgt = q_fb;
    endcase
  end

  // Set/reset excitation only; the toggle code is never produced.
  assign j = step_en ? (tgt & ~q_fb) : '0;
  assign k = step_en ? (~tgt & q_fb) : '0;

  assign wrap_hit = step_en && ((op_q == OP_UP && (&q_fb)) ||
                                (op_q == OP_DOWN && (q_fb == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_LOAD;
      data_q <= '0;
      rem    <= '0;
      wrap   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        rem    <= start_rem;
        wrap   <= 1'b0;
      end else if (step_en) begin
        rem <= rem - CNT_W'(1);
        if (wrap_hit) wrap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Directed bench for jk_count_ctrl with a behavioural JK bank in the feedback path.
// Expected final bank value and wrap are queued at command issue and checked at done.
module tb_jk_count_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             wrap;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             wrap;

  logic [WIDTH-1:0] bank = 4'h3;
  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;

  jk_count_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .q_fb(q_fb),
    .j(j), .k(k), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank; only the controller's excitation changes it.
  always @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b10:   bank[i] <= 1'b1;
        2'b01:   bank[i] <= 1'b0;
        2'b11:   bank[i] <= ~bank[i];
        default: bank[i] <= bank[i];
      endcase
    end
  end
  assign q_fb = bank;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(q_fb), 32'(e.q));
      chk({tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data,
                      input logic [CNT_W-1:0] len, input exp_t e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = WIDTH'($urandom);
    cmd_len   = CNT_W'($urandom);
  endtask

  // Counts cycles from the first post-accept cycle until done, checks against
  // the scoreboard, then steps into IDLE.
  task automatic wait_done(input int exp_n, input string tag);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_cycle"}, 32'(n), 32'(exp_n));
    if (done) sb_check(tag);
    @(negedge clk);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'(1));
  endtask

  initial begin
    logic [WIDTH-1:0] up_seq [4];
    up_seq = '{4'hE, 4'hF, 4'h0, 4'h1};
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    cmd_len   = '0;

    // Reset state
    @(negedge clk);
    chk("rst_j", 32'(j), 32'(0));
    chk("rst_k", 32'(k), 32'(0));
    chk("rst_ready", 32'(cmd_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_wrap", 32'(wrap), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 0xA onto 0x3
    send(2'b00, 4'hA, 8'd7, '{q: 4'hA, wrap: 1'b0});
    chk("load_j", 32'(j), 32'(4'h8));
    chk("load_k", 32'(k), 32'(4'h1));
    chk("load_busy", 32'(busy), 32'(1));
    chk("load_ready", 32'(cmd_ready), 32'(0));
    wait_done(1, "load");

    // UP 3 from 0xE, wrapping through 0xF->0x0
    send(2'b00, 4'hE, 8'd0, '{q: 4'hE, wrap: 1'b0});
    wait_done(1, "ld_e");
    send(2'b01, 4'h0, 8'd3, '{q: 4'h1, wrap: 1'b1});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("up_q%0d", i), 32'(q_fb), 32'(up_seq[i]));
      chk($sformatf("up_busy%0d", i), 32'(busy), 32'(1));
      chk($sformatf("up_done%0d", i), 32'(done), 32'(i == 3));
      if (i == 3) sb_check("up");
      else @(negedge clk);
    end
    @(negedge clk);
    chk("up_busy_end", 32'(busy), 32'(0));
    chk("up_ready_end", 32'(cmd_ready), 32'(1));
    chk("up_wrap_sticky", 32'(wrap), 32'(1));

    // DOWN 2 from 0x1
    send(2'b00, 4'h1, 8'd0, '{q: 4'h1, wrap: 1'b0});
    wait_done(1, "ld_1");
    send(2'b10, 4'h0, 8'd2, '{q: 4'hF, wrap: 1'b1});
    chk("dn_j", 32'(j), 32'(4'h0));
    chk("dn_k", 32'(k), 32'(4'h1));
    @(negedge clk);
    chk("dn_q_mid", 32'(q_fb), 32'(4'h0));
    wait_done(1, "dn");

    // UP with cmd_len=0 on 0x5
    send(2'b00, 4'h5, 8'd0, '{q: 4'h5, wrap: 1'b0});
    wait_done(1, "ld_5");
    chk("z_idle_j", 32'(j | k), 32'(0));
    send(2'b01, 4'h0, 8'd0, '{q: 4'h5, wrap: 1'b0});
    chk("z_jk", 32'(j | k), 32'(0));
    chk("z_done_now", 32'(done), 32'(1));
    wait_done(0, "zero");

    // CLEAR then UP 1 with cmd_valid held
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = 8'd0;
    sb.push_back('{q: 4'h0, wrap: 1'b0});
    @(negedge clk);
    chk("hold_run_ready", 32'(cmd_ready), 32'(0));
    cmd_op  = 2'b01;
    cmd_len = 8'd1;
    sb.push_back('{q: 4'h1, wrap: 1'b0});
    @(negedge clk);
    chk("hold_done", 32'(done), 32'(1));
    chk("hold_done_ready", 32'(cmd_ready), 32'(0));
    sb_check("clear");
    @(negedge clk);
    chk("hold_idle_ready", 32'(cmd_ready), 32'(1));
    chk("hold_idle_busy", 32'(busy), 32'(0));
    @(negedge clk);
    chk("hold_acc_busy", 32'(busy), 32'(1));
    chk("hold_acc_j", 32'(j), 32'(4'h1));
    cmd_valid = 1'b0;
    wait_done(1, "hold_up");

    // Reset in the middle of UP 10 from 0x0
    send(2'b00, 4'h0, 8'd0, '{q: 4'h0, wrap: 1'b0});
    wait_done(1, "ld_0");
    send(2'b01, 4'h0, 8'd10, '{q: 4'hA, wrap: 1'b0});
    repeat (4) @(negedge clk);
    chk("abort_q_pre", 32'(q_fb), 32'(4'h4));
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_jk", 32'(j | k), 32'(0));
    chk("abort_ready", 32'(cmd_ready), 32'(1));
    chk("abort_busy", 32'(busy), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone%0d", i), 32'(done), 32'(0));
    end
    rst_n = 1'b1;
    chk("abort_hold", 32'(q_fb), 32'(4'h4));
    chk("abort_wrap", 32'(wrap), 32'(0));
    send(2'b01, 4'h0, 8'd2, '{q: 4'h6, wrap: 1'b0});
    wait_done(2, "post_rst");

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // The toggle code must never appear on any bit.
  always @(negedge clk) begin
    if (rst_n) chk("no_toggle", 32'(j & k), 32'(0));
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
